// File: rtl/reg_hazard_scoreboard.sv
// Register hazard scoreboard: tracks in-flight writes from ID through a shadow pipeline and
// drives the ID stall. Define REG_HAZARD_FORWARD_EN to enable per-port forwarding selects.
module reg_hazard_scoreboard #(
  parameter int REG_W      = 6,
  parameter int NUM_RD     = 2,
  parameter int PIPE_DEPTH = 3,
  parameter int LATE_STAGE = 1,
  parameter int CNT_W      = 32,
  localparam int FS_W      = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [NUM_RD*REG_W-1:0]  id_rd_addr,
  input  logic [REG_W-1:0]         id_wr_addr,
  input  logic                     id_wr_late,
  input  logic                     advance,
  input  logic [PIPE_DEPTH-1:0]    flush_mask,
  input  logic                     id_flush,
  output logic                     stall,
  output logic [NUM_RD*FS_W-1:0]   fwd_sel,
  output logic [FS_W-1:0]          busy_cnt,
  output logic [CNT_W-1:0]         stall_cycles
);

  logic [PIPE_DEPTH-1:0] ent_v;
  logic [PIPE_DEPTH-1:0] ent_late;
  logic [REG_W-1:0]      ent_addr [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] kept_v;
  logic [NUM_RD-1:0]     port_hz;
  logic                  ins_v;

  // The last stage is writing back this cycle and the RF bypasses it, so it is never scanned.
  always_comb begin
    port_hz = '0;
    fwd_sel = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      logic hit;
`ifdef REG_HAZARD_FORWARD_EN
      logic [FS_W-1:0] hit_idx;
      hit_idx = '0;
`endif
      hit = 1'b0;
      for (int i = PIPE_DEPTH - 2; i >= 0; i--) begin
        if (ent_v[i] && (ent_addr[i] == id_rd_addr[p*REG_W +: REG_W]) &&
            (id_rd_addr[p*REG_W +: REG_W] != '0)) begin
          hit = 1'b1;
`ifdef REG_HAZARD_FORWARD_EN
          hit_idx = i[FS_W-1:0];
`endif
        end
      end
`ifdef REG_HAZARD_FORWARD_EN
      if (hit && ent_late[hit_idx] && (int'(hit_idx) < LATE_STAGE)) begin
        port_hz[p] = 1'b1;
      end else if (hit) begin
        fwd_sel[p*FS_W +: FS_W] = hit_idx + FS_W'(1);
      end
`else
      port_hz[p] = hit;
`endif
    end
  end

`ifndef REG_HAZARD_FORWARD_EN
  // Late flag is kept in the entries so both builds share the same storage.
  logic late_unused;
  assign late_unused = ^ent_late ^ (LATE_STAGE != 0);
`endif

  assign stall  = id_valid & ~id_flush & (|port_hz);
  assign ins_v  = id_valid & ~id_flush & ~stall & (id_wr_addr != '0);
  assign kept_v = ent_v & ~flush_mask;

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      busy_cnt = busy_cnt + FS_W'(ent_v[i]);
    end
  end

  // Flush is applied before the shift so a squashed entry moves on as a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_v    <= '0;
      ent_late <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        ent_addr[i] <= '0;
      end
    end else if (advance) begin
      ent_v       <= {kept_v[PIPE_DEPTH-2:0], ins_v};
      ent_late    <= {ent_late[PIPE_DEPTH-2:0], id_wr_late};
      ent_addr[0] <= id_wr_addr;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        ent_addr[i] <= ent_addr[i-1];
      end
    end else begin
      ent_v <= kept_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// Bench for reg_hazard_scoreboard: directed vectors, a per-cycle model compare and literal checks.
// A second instance with a 4-bit stall counter exercises saturation on the same stimulus.
module tb_reg_hazard_scoreboard;
  localparam int REG_W = 6;
  localparam int NUM_RD = 2;
  localparam int PD = 3;
  localparam int LATE = 1;
  localparam int FS_W = 2;
`ifdef REG_HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid, id_wr_late, advance, id_flush;
  logic [NUM_RD*REG_W-1:0] id_rd_addr;
  logic [REG_W-1:0] id_wr_addr;
  logic [PD-1:0] flush_mask;
  logic stall, stall_s;
  logic [NUM_RD*FS_W-1:0] fwd, fwd_s;
  logic [FS_W-1:0] busy, busy_s;
  logic [31:0] cyc32;
  logic [3:0] cyc4;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd_addr(id_rd_addr),
    .id_wr_addr(id_wr_addr), .id_wr_late(id_wr_late), .advance(advance),
    .flush_mask(flush_mask), .id_flush(id_flush), .stall(stall), .fwd_sel(fwd),
    .busy_cnt(busy), .stall_cycles(cyc32)
  );

  reg_hazard_scoreboard #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd_addr(id_rd_addr),
    .id_wr_addr(id_wr_addr), .id_wr_late(id_wr_late), .advance(advance),
    .flush_mask(flush_mask), .id_flush(id_flush), .stall(stall_s), .fwd_sel(fwd_s),
    .busy_cnt(busy_s), .stall_cycles(cyc4)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: list of in-flight writes, index 0 = youngest (EX).
  int m_v [PD];
  int m_addr [PD];
  int m_late [PD];
  longint m_cnt, m_cnt4;

  function automatic int f_young(input int p);
    int src = int'(id_rd_addr[p*REG_W +: REG_W]);
    f_young = -1;
    for (int i = PD - 2; i >= 0; i--)
      if (m_v[i] != 0 && m_addr[i] == src && src != 0) f_young = i;
  endfunction

  function automatic bit f_blocks(input int y);
`ifdef REG_HAZARD_FORWARD_EN
    return (y >= 0) && (m_late[y] != 0) && (y < LATE);
`else
    return (y >= 0);
`endif
  endfunction

  function automatic logic f_stall();
    bit haz = 0;
    for (int p = 0; p < NUM_RD; p++) if (f_blocks(f_young(p))) haz = 1;
    return id_valid && !id_flush && haz;
  endfunction

  function automatic logic [NUM_RD*FS_W-1:0] f_fwd();
    logic [NUM_RD*FS_W-1:0] r = '0;
`ifdef REG_HAZARD_FORWARD_EN
    for (int p = 0; p < NUM_RD; p++) begin
      int y = f_young(p);
      if (y >= 0 && !f_blocks(y)) r[p*FS_W +: FS_W] = FS_W'(y + 1);
    end
`endif
    return r;
  endfunction

  function automatic int f_busy();
    int n = 0;
    for (int i = 0; i < PD; i++) if (m_v[i] != 0) n++;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PD; i++) m_v[i] <= 0;
      m_cnt <= 0;
      m_cnt4 <= 0;
    end else begin
      if (f_stall()) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt4 < 15) m_cnt4 <= m_cnt4 + 1;
      end
      if (advance) begin
        m_v[0] <= (id_valid && !id_flush && !f_stall() && id_wr_addr != 0) ? 1 : 0;
        m_addr[0] <= int'(id_wr_addr);
        m_late[0] <= int'(id_wr_late);
        for (int i = 1; i < PD; i++) begin
          m_v[i] <= (m_v[i-1] != 0 && !flush_mask[i-1]) ? 1 : 0;
          m_addr[i] <= m_addr[i-1];
          m_late[i] <= m_late[i-1];
        end
      end else begin
        for (int i = 0; i < PD; i++) if (flush_mask[i]) m_v[i] <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("stall", stall, f_stall());
      chk("fwd_sel", fwd, f_fwd());
      chk("busy_cnt", busy, f_busy());
      chk("stall_cycles", cyc32, m_cnt);
      chk("stall_cycles_w4", cyc4, m_cnt4);
      chk("stall_w4", stall_s, f_stall());
    end
  end

  task automatic set_in(input bit v, input int rd0, input int rd1, input int wr, input bit late);
    id_valid = v;
    id_rd_addr = {REG_W'(rd1), REG_W'(rd0)};
    id_wr_addr = REG_W'(wr);
    id_wr_late = late;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0);
    advance = 1; flush_mask = '0; id_flush = 0;
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", cyc32, 0);
    cyc(); cyc();
    rst_n = 1;

    // RAW on port 0
    set_in(1, 0, 0, 8, 0);
    @(negedge clk); chk("t2_issue_stall", stall, 0); chk("t2_issue_busy", busy, 0);
    cyc();
    set_in(1, 8, 0, 0, 0);
    @(negedge clk); chk("t2_c1_stall", stall, !FWD); chk("t2_c1_fwd", fwd, FWD ? 1 : 0);
    chk("t2_c1_busy", busy, 1);
    cyc();
    @(negedge clk); chk("t2_c2_stall", stall, !FWD); chk("t2_c2_fwd", fwd, FWD ? 2 : 0);
    cyc();
    @(negedge clk); chk("t2_c3_stall", stall, 0); chk("t2_c3_fwd", fwd, 0);
    chk("t2_cnt", cyc32, FWD ? 0 : 2);
    cyc();
    set_in(0, 0, 0, 0, 0);
    cyc();
    @(negedge clk); chk("t2_drained", busy, 0);
    cyc();

    // Late result read on port 1
    set_in(1, 0, 0, 9, 1);
    cyc();
    set_in(1, 0, 9, 0, 0);
    @(negedge clk); chk("t3_c1_stall", stall, 1); chk("t3_c1_fwd", fwd, 0);
    cyc();
    @(negedge clk); chk("t3_c2_stall", stall, !FWD); chk("t3_c2_fwd", fwd, FWD ? 8 : 0);
    cyc();
    @(negedge clk); chk("t3_c3_stall", stall, 0); chk("t3_cnt", cyc32, FWD ? 1 : 4);
    cyc();
    set_in(0, 0, 0, 0, 0);
    cyc(); cyc();

    // Register 0, squashed write, HI/LO pair
    set_in(1, 0, 0, 0, 0);
    cyc();
    @(negedge clk); chk("t4_r0_busy", busy, 0); chk("t4_r0_stall", stall, 0);
    cyc();
    set_in(1, 0, 0, 20, 0); id_flush = 1;
    cyc();
    id_flush = 0; set_in(1, 20, 20, 0, 0);
    @(negedge clk); chk("t4_flushed_busy", busy, 0); chk("t4_flushed_stall", stall, 0);
    cyc();
    set_in(1, 0, 0, 33, 0);
    cyc();
    set_in(1, 33, 0, 34, 0);
    @(negedge clk); chk("t4_hilo_stall", stall, !FWD); chk("t4_hilo_fwd", fwd, FWD ? 1 : 0);
    id_flush = 1; #1 chk("t4_idflush_stall", stall, 0);
    id_flush = 0; id_valid = 0; #1 chk("t4_invalid_stall", stall, 0);
    id_valid = 1;
    cyc();
    @(negedge clk); chk("t4_hilo2_stall", stall, !FWD); chk("t4_hilo2_fwd", fwd, FWD ? 2 : 0);
    cyc();
    set_in(0, 0, 0, 0, 0);
    cyc(); cyc(); cyc();

    // Freeze and flush
    set_in(1, 0, 0, 11, 0);
    cyc();
    set_in(1, 0, 0, 10, 0);
    cyc();
    set_in(1, 10, 11, 0, 0); advance = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("t5_frz_busy", busy, 2); chk("t5_frz_stall", stall, !FWD);
      chk("t5_frz_fwd", fwd, FWD ? 9 : 0);
      cyc();
    end
    flush_mask = 3'b001;
    @(negedge clk); chk("t5_fl_busy", busy, 2);
    cyc();
    flush_mask = '0; advance = 1;
    @(negedge clk); chk("t5_post_busy", busy, 1); chk("t5_post_stall", stall, !FWD);
    chk("t5_post_fwd", fwd, FWD ? 8 : 0);
    cyc();
    @(negedge clk); chk("t5_wb_stall", stall, 0); chk("t5_wb_busy", busy, 1);
    cyc();
    set_in(0, 0, 0, 0, 0);
    cyc();
    set_in(1, 0, 0, 12, 0);
    cyc();
    set_in(0, 0, 0, 0, 0); flush_mask = 3'b001;
    cyc();
    flush_mask = '0;
    @(negedge clk); chk("t5_bubble_busy", busy, 0);
    cyc();

    // Saturation of the 4-bit counter
    set_in(1, 0, 0, 13, 1);
    cyc();
    set_in(1, 13, 0, 0, 0); advance = 0;
    repeat (20) cyc();
    @(negedge clk); chk("t6_sat", cyc4, 15); chk("t6_stall", stall, 1);
    cyc();
    @(negedge clk); chk("t6_sat_hold", cyc4, 15);

    // Asynchronous reset with entries valid
    #2 rst_n = 0;
    #1;
    chk("t1_stall", stall, 0);
    chk("t1_busy", busy, 0);
    chk("t1_cnt", cyc32, 0);
    chk("t1_cnt_w4", cyc4, 0);
    @(posedge clk); #1 rst_n = 1;
    advance = 1;
    set_in(1, 0, 0, 8, 0);
    cyc();
    set_in(1, 8, 0, 0, 0);
    @(negedge clk); chk("t1_after_stall", stall, !FWD); chk("t1_after_busy", busy, 1);
    chk("t1_after_cnt", cyc32, 0);
    cyc();
    set_in(0, 0, 0, 0, 0);
    cyc(); cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
